full_adder: RTL and testbench



---
 rtl/full_adder.sv | 68 ++++++
 tb/tb_full_adder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder built from full-adder bit cells.
// Optional overflow output and flop enabled by defining FULL_ADDER_OVF_EN.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             valid_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum_d[i]   = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  // Result flops load only on a qualified edge, so X on idle inputs never enters state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= carry[WIDTH];
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

`ifdef FULL_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed and randomized checks for full_adder at WIDTH 1, 32 and 8.
// Overflow checks are compiled in when FULL_ADDER_OVF_EN is defined.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v1, v32, v8;
  logic        a1, b1, cin1, cin32, cin8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        s1, co1, ov1;
  logic [31:0] s32;
  logic        co32, ov32;
  logic [7:0]  s8;
  logic        co8, ov8;
  logic        ovf1, ovf32, ovf8;

  int n_cmp = 0;
  int n_err = 0;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
    .sum(s1), .cout(co1), .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  full_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(v32), .a(a32), .b(b32), .cin(cin32),
    .sum(s32), .cout(co32), .out_valid(ov32)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf32)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(cin8),
    .sum(s8), .cout(co8), .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

`ifndef FULL_ADDER_OVF_EN
  assign ovf1  = 1'b0;
  assign ovf32 = 1'b0;
  assign ovf8  = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {a,b,cin} stimulus and {sum,cout} results, hand-computed
  logic [2:0] tt_in  [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
  logic [1:0] tt_exp [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  initial begin
    logic [8:0] ref8;
    logic       ref_ovf8;
    logic       ref_v8;
    int         lo;

    rst = 1'b1;
    {v1, v32, v8} = '0;
    {a1, b1, cin1, cin32, cin8} = '0;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    step();
    step();
    check("rst_w1_sum", s1, 0);
    check("rst_w1_cout", co1, 0);
    check("rst_w1_valid", ov1, 0);
    check("rst_w32_sum", s32, 0);
    check("rst_w8_valid", ov8, 0);
`ifdef FULL_ADDER_OVF_EN
    check("rst_w1_ovf", ovf1, 0);
`endif
    rst = 1'b0;

    // Truth table, back-to-back
    for (int i = 0; i < 8; i++) begin
      logic [2:0] t;
      logic [1:0] e;
      t = tt_in[i];
      e = tt_exp[i];
      v1 = 1'b1; a1 = t[2]; b1 = t[1]; cin1 = t[0];
      step();
      check($sformatf("tt%0d_sum", i), s1, e[1]);
      check($sformatf("tt%0d_cout", i), co1, e[0]);
      check($sformatf("tt%0d_valid", i), ov1, 1);
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("tt%0d_ovf", i), ovf1, e[0] ^ t[0]);
`endif
    end

    // Hold with toggling and unknown inputs while idle
    for (int i = 0; i < 3; i++) begin
      v1 = 1'b0;
      if (i == 1) begin
        a1 = 1'bx; b1 = 1'bx; cin1 = 1'bx;
      end else begin
        a1 = i[0]; b1 = ~i[0]; cin1 = 1'b0;
      end
      step();
      check($sformatf("hold%0d_sum", i), s1, 1);
      check($sformatf("hold%0d_cout", i), co1, 1);
      check($sformatf("hold%0d_valid", i), ov1, 0);
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("hold%0d_ovf", i), ovf1, 0);
`endif
    end

    // Reset overrides a valid transaction on the same edge
    rst = 1'b1; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    step();
    check("rstv_sum", s1, 0);
    check("rstv_cout", co1, 0);
    check("rstv_valid", ov1, 0);
    rst = 1'b0; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
    step();
    check("post_rst_sum", s1, 0);
    check("post_rst_cout", co1, 1);
    check("post_rst_valid", ov1, 1);
    v1 = 1'b0;

    // Full-width carry ripple
    v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1;
    step();
    check("w32_ripple_sum", s32, 32'h0);
    check("w32_ripple_cout", co32, 1);
    check("w32_ripple_valid", ov32, 1);
`ifdef FULL_ADDER_OVF_EN
    check("w32_ripple_ovf", ovf32, 0);
`endif
    a32 = 32'h7FFF_FFFF; b32 = 32'h1; cin32 = 1'b0;
    step();
    check("w32_sign_sum", s32, 32'h8000_0000);
    check("w32_sign_cout", co32, 0);
`ifdef FULL_ADDER_OVF_EN
    check("w32_sign_ovf", ovf32, 1);
`endif
    v32 = 1'b0;
    step();
    check("w32_idle_valid", ov32, 0);
    check("w32_idle_sum", s32, 32'h8000_0000);

    // Random back-to-back at WIDTH=8 against a reference model
    ref8 = '0;
    ref_ovf8 = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      v8   = 1'($urandom_range(0, 1));
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom_range(0, 1));
      ref_v8 = v8;
      if (v8) begin
        ref8 = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
        lo = int'(a8[6:0]) + int'(b8[6:0]) + int'(cin8);
        ref_ovf8 = ref8[8] ^ lo[7];
      end
      step();
      check("rnd_sum", s8, ref8[7:0]);
      check("rnd_cout", co8, ref8[8]);
      check("rnd_valid", ov8, ref_v8);
`ifdef FULL_ADDER_OVF_EN
      check("rnd_ovf", ovf8, ref_ovf8);
`else
      if (ref_ovf8 && ovf8) n_err = n_err;
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
